// File: rtl/sar_comparator_ctrl.sv
// Successive-approximation controller: steps a binary trial code on the DAC,
// strobes the clocked comparator once per bit and assembles the result MSB-first.
module sar_comparator_ctrl #(
  parameter int N_BITS        = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmp_out,
  output logic              cmp_clk,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IDX_W-1:0]  MSB_IDX  = IDX_W'(N_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [N_BITS-1:0] MSB_CODE = N_BITS'(1) << (N_BITS - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    STROBE = 3'd2,
    EVAL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // With no settle time the DAC code goes straight to the comparator strobe.
  localparam state_t BIT_FIRST = (SETTLE_CYCLES == 0) ? STROBE : SETTLE;

  state_t            state, state_d;
  logic [IDX_W-1:0]  bit_idx, bit_idx_d;
  logic [3:0]        cnt, cnt_d;
  logic [N_BITS-1:0] code_d;
  logic [N_BITS-1:0] result_d;

  // Resolve the current bit from the decision and raise the next trial bit.
  function automatic logic [N_BITS-1:0] next_trial(
    input logic [N_BITS-1:0] code,
    input logic [IDX_W-1:0]  idx,
    input logic              decision
  );
    logic [N_BITS-1:0] t;
    t = code;
    if (!decision) t[idx] = 1'b0;
    if (idx != '0) t[idx - IDX_ONE] = 1'b1;
    return t;
  endfunction

  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx;
    cnt_d     = cnt;
    code_d    = dac_code;
    result_d  = result;
    case (state)
      IDLE: begin
        if (start) begin
          bit_idx_d = MSB_IDX;
          code_d    = MSB_CODE;
          cnt_d     = '0;
          state_d   = BIT_FIRST;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      STROBE: state_d = EVAL;
      EVAL: begin
        code_d = next_trial(dac_code, bit_idx, cmp_out);
        if (bit_idx != '0) begin
          bit_idx_d = bit_idx - IDX_ONE;
          cnt_d     = '0;
          state_d   = BIT_FIRST;
        end else begin
          result_d = code_d;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_idx  <= '0;
      cnt      <= '0;
      dac_code <= '0;
      result   <= '0;
      cmp_clk  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      bit_idx  <= bit_idx_d;
      cnt      <= cnt_d;
      dac_code <= code_d;
      result   <= result_d;
      cmp_clk  <= (state_d == STROBE);
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_sar_comparator_ctrl.sv
// Scoreboard bench for sar_comparator_ctrl: 8-bit/2-settle and 4-bit/0-settle
// instances driven against a strict-compare comparator model, DAC full scale 10 V.
`timescale 1ns/1ps
module tb_sar_comparator_ctrl;

  typedef struct {
    int res;
    int dedge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic cmp_a = 1'b0, cmp_b = 1'b0;
  logic cmp_clk_a, cmp_clk_b;
  logic [7:0] dac_a, result_a;
  logic [3:0] dac_b, result_b;
  logic busy_a, done_a, busy_b, done_b;

  int inp_a = 0, inp_b = 0;   // analog input in millivolts
  int cyc = 0;
  int checks = 0, errors = 0;
  int n_done_a = 0, n_done_b = 0;
  int pulses_a = 0, pulses_b = 0;
  int hold_a = 0, hold_b = 0;
  int st_b = 0;
  logic prev_cc_a = 1'b0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;

  sar_comparator_ctrl #(.N_BITS(8), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cmp_out(cmp_a),
    .cmp_clk(cmp_clk_a), .dac_code(dac_a), .busy(busy_a), .done(done_a),
    .result(result_a)
  );

  sar_comparator_ctrl #(.N_BITS(4), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cmp_out(cmp_b),
    .cmp_clk(cmp_clk_b), .dac_code(dac_b), .busy(busy_b), .done(done_b),
    .result(result_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator: in_p > code * 10V / 2^N, captured on the rising strobe.
  always @(posedge cmp_clk_a) cmp_a <= (inp_a * 256 > int'(dac_a) * 10000);
  always @(posedge cmp_clk_b) cmp_b <= (inp_b * 16 > int'(dac_b) * 10000);

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pulses_a  = 0;
      prev_cc_a = 1'b0;
      hold_a    = 0;
    end else begin
      if (cmp_clk_a) begin
        chk("a_cmpclk_single_cycle", int'(prev_cc_a), 0);
        pulses_a++;
      end
      prev_cc_a = cmp_clk_a;
      if (done_a) begin
        if (sb_a.size() == 0) begin
          chk("a_unexpected_done", 1, 0);
        end else begin
          ea = sb_a.pop_front();
          chk("a_result", int'(result_a), ea.res);
          chk("a_dac_final", int'(dac_a), ea.res);
          chk("a_done_edge", cyc, ea.dedge);
          chk("a_pulses", pulses_a, 8);
          chk("a_busy_in_done", int'(busy_a), 1);
          hold_a = ea.res;
        end
        pulses_a = 0;
        n_done_a++;
      end else begin
        chk("a_result_hold", int'(result_a), hold_a);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pulses_b = 0;
      hold_b   = 0;
    end else begin
      if (cmp_clk_b) pulses_b++;
      if (busy_b && !done_b)
        chk("b_cmpclk_alternate", int'(cmp_clk_b), int'(((cyc - st_b) % 2) == 0));
      if (done_b) begin
        if (sb_b.size() == 0) begin
          chk("b_unexpected_done", 1, 0);
        end else begin
          eb = sb_b.pop_front();
          chk("b_result", int'(result_b), eb.res);
          chk("b_done_edge", cyc, eb.dedge);
          chk("b_pulses", pulses_b, 4);
          hold_b = eb.res;
        end
        pulses_b = 0;
        n_done_b++;
      end else begin
        chk("b_result_hold", int'(result_b), hold_b);
      end
    end
  end

  task automatic wait_a(input int target, input int budget);
    for (int i = 0; i < budget && n_done_a < target; i++) @(posedge clk);
    if (n_done_a < target) chk("a_done_timeout", n_done_a, target);
  endtask

  task automatic wait_b(input int target, input int budget);
    for (int i = 0; i < budget && n_done_b < target; i++) @(posedge clk);
    if (n_done_b < target) chk("b_done_timeout", n_done_b, target);
  endtask

  task automatic conv_a(input int mv, input int res);
    int tgt;
    tgt = n_done_a + 1;
    @(negedge clk);
    inp_a   = mv;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    sb_a.push_back('{res: res, dedge: cyc + 32});
    start_a = 1'b0;
    wait_a(tgt, 60);
  endtask

  task automatic conv_b(input int mv, input int res);
    int tgt;
    tgt = n_done_b + 1;
    @(negedge clk);
    inp_b   = mv;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    st_b = cyc;
    sb_b.push_back('{res: res, dedge: cyc + 8});
    start_b = 1'b0;
    wait_b(tgt, 20);
  endtask

  initial begin
    int e0;
    int tgt;
    #12;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_cmp_clk", int'(cmp_clk_a), 0);
    chk("rst_dac", int'(dac_a), 0);
    chk("rst_result", int'(result_a), 0);
    chk("rst_b_result", int'(result_b), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    conv_a(3450, 8'h58);
    conv_a(0, 8'h00);
    conv_a(10000, 8'hFF);
    conv_a(5000, 8'h7F);

    // Extra start pulse mid-conversion must be ignored.
    tgt = n_done_a + 1;
    @(negedge clk);
    inp_a   = 2000;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    sb_a.push_back('{res: 51, dedge: cyc + 32});
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_a(tgt, 60);
    repeat (40) @(posedge clk);
    chk("a_no_extra_done", n_done_a, tgt);

    // Held start: conversions accepted only from IDLE, 34 edges apart.
    tgt = n_done_a + 3;
    @(negedge clk);
    inp_a   = 5000;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    sb_a.push_back('{res: 8'h7F, dedge: e0 + 32});
    sb_a.push_back('{res: 8'h7F, dedge: e0 + 66});
    sb_a.push_back('{res: 8'h7F, dedge: e0 + 100});
    wait_a(tgt, 150);
    #1 start_a = 1'b0;
    repeat (40) @(posedge clk);
    chk("a_held_count", n_done_a, tgt);

    // Reset during the 4th bit's settle window.
    @(negedge clk);
    inp_a   = 3450;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    sb_a.delete();
    #1;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_cmp_clk", int'(cmp_clk_a), 0);
    chk("abort_result", int'(result_a), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy_a), 0);
    chk("idle_done", int'(done_a), 0);
    chk("idle_cmp_clk", int'(cmp_clk_a), 0);
    chk("idle_dac", int'(dac_a), 0);
    chk("idle_result", int'(result_a), 0);

    conv_b(6300, 4'hA);
    conv_b(0, 4'h0);
    conv_b(10000, 4'hF);
    conv_b(5000, 4'h7);

    repeat (5) @(posedge clk);
    chk("a_sb_empty", sb_a.size(), 0);
    chk("b_sb_empty", sb_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
